// File: rtl/maze_rom_arbiter.sv
// Shares the single maze-ROM read port between the display (always first) and game-logic wall queries.
// Define MAZE_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module maze_rom_arbiter #(
    parameter int NUM_REQ  = 5,
    parameter int MAP_ROWS = 310,
    parameter int MAP_COLS = 280
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   disp_active,
    input  logic [8:0]             disp_row,
    input  logic [8:0]             disp_col,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*9-1:0]   req_row,
    input  logic [NUM_REQ*9-1:0]   req_col,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_wall,
    output logic [8:0]             rom_row,
    output logic [8:0]             rom_col,
    output logic                   rom_en,
    input  logic [11:0]            rom_data,
    output logic [11:0]            disp_rgb,
    output logic                   disp_wall
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DISP, QUERY} state_t;
    state_t state;

    logic [IW-1:0] win_idx;
    logic          any_req;
    logic [8:0]    q_row [NUM_REQ];
    logic [8:0]    q_col [NUM_REQ];
    logic [8:0]    sel_row, sel_col;
    logic          sel_oor;
    logic          disp_q;
    logic          oor_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            q_row[i] = req_row[9*i +: 9];
            q_col[i] = req_col[9*i +: 9];
        end
    end

`ifdef MAZE_ARB_RR_EN
    logic [IW-1:0] rr_ptr;

    // Walk upward from the pointer, wrapping, and take the first pending requester.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) win_idx = IW'(i);
    end
`endif

    assign any_req = |req;
    assign sel_row = q_row[win_idx];
    assign sel_col = q_col[win_idx];
    assign sel_oor = (int'(sel_row) >= MAP_ROWS) || (int'(sel_col) >= MAP_COLS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            rom_en    <= 1'b0;
            rom_row   <= '0;
            rom_col   <= '0;
            rsp_valid <= '0;
            oor_q     <= 1'b0;
            disp_q    <= 1'b0;
`ifdef MAZE_ARB_RR_EN
            rr_ptr    <= '0;
`endif
        end else begin
            rsp_valid <= gnt;
            // A grant without a ROM enable marks an out-of-range query.
            oor_q     <= (state == QUERY) && !rom_en;
            disp_q    <= (state == DISP);
            gnt       <= '0;
            rom_en    <= 1'b0;
            rom_row   <= '0;
            rom_col   <= '0;
            if (disp_active) begin
                state   <= DISP;
                rom_en  <= 1'b1;
                rom_row <= disp_row;
                rom_col <= disp_col;
            end else if (any_req) begin
                state   <= QUERY;
                gnt     <= NUM_REQ'(1) << win_idx;
                rom_en  <= !sel_oor;
                rom_row <= sel_row;
                rom_col <= sel_col;
`ifdef MAZE_ARB_RR_EN
                rr_ptr  <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
            end else begin
                state <= IDLE;
            end
        end
    end

    // ROM data lands the cycle after the access, so the result side is a thin qualifier.
    assign rsp_wall  = (|rsp_valid) && (oor_q || (rom_data != 12'h000));
    assign disp_rgb  = disp_q ? rom_data : 12'h000;
    assign disp_wall = disp_q && (rom_data != 12'h000);

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Bench for maze_rom_arbiter: cycle model from the arbitration rules, plus directed literal checks.
module tb_maze_rom_arbiter;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           disp_active = 1'b0;
    logic [8:0]     disp_row = '0, disp_col = '0;
    logic [N-1:0]   req = '0;
    logic [N*9-1:0] req_row = '0, req_col = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic           rsp_wall, rom_en, disp_wall;
    logic [8:0]     rom_row, rom_col;
    logic [11:0]    rom_data = 12'h000;
    logic [11:0]    disp_rgb;

    int checks = 0;
    int errors = 0;

    maze_rom_arbiter dut (
        .clk(clk), .reset(reset), .disp_active(disp_active),
        .disp_row(disp_row), .disp_col(disp_col),
        .req(req), .req_row(req_row), .req_col(req_col),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_wall(rsp_wall),
        .rom_row(rom_row), .rom_col(rom_col), .rom_en(rom_en),
        .rom_data(rom_data), .disp_rgb(disp_rgb), .disp_wall(disp_wall)
    );

    always #5 clk = ~clk;

    // Synthetic maze: (0,0) is 12'h00F, odd-parity pixels are floor, the rest coloured wall.
    function automatic logic [11:0] rom_color(input logic [8:0] r, input logic [8:0] c);
        if (r == 9'd0 && c == 9'd0) return 12'h00F;
        if (r[0] ^ c[0]) return 12'h000;
        return {r[3:0], c[3:0], 4'hA};
    endfunction

    always @(posedge clk)
        if (rom_en) rom_data <= rom_color(rom_row, rom_col);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: what each output must show in the cycle after every edge.
    logic [N-1:0] m_gnt = '0, m_rsp_valid = '0;
    logic         m_en = 1'b0, m_oor = 1'b0, m_is_disp = 1'b0, m_rsp_wall = 1'b0;
    logic [8:0]   m_row = '0, m_col = '0;
    logic [11:0]  m_disp_rgb = '0;
    int           m_ptr = 0;
    bit           model_ready = 1'b0;

    initial forever begin
        int w, r, c;
        @(posedge clk);
        m_rsp_valid = m_gnt;
        m_rsp_wall  = (m_gnt != 0) && (m_oor || rom_color(m_row, m_col) != 12'h000);
        m_disp_rgb  = m_is_disp ? rom_color(m_row, m_col) : 12'h000;
        m_gnt = '0; m_en = 1'b0; m_oor = 1'b0; m_is_disp = 1'b0;
        if (reset) begin
            m_rsp_valid = '0; m_rsp_wall = 1'b0; m_disp_rgb = '0; m_ptr = 0;
            model_ready = 1'b1;
        end else if (disp_active) begin
            m_is_disp = 1'b1; m_en = 1'b1; m_row = disp_row; m_col = disp_col;
        end else if (req != 0) begin
            w = -1;
`ifdef MAZE_ARB_RR_EN
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_ptr = (w + 1) % N;
`else
            for (int k = N - 1; k >= 0; k--)
                if (req[k]) w = k;
`endif
            r = int'(req_row[9*w +: 9]);
            c = int'(req_col[9*w +: 9]);
            m_gnt = N'(1) << w;
            m_oor = (r >= 310) || (c >= 280);
            m_en  = !m_oor;
            m_row = 9'(r); m_col = 9'(c);
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ready) begin
            chk("gnt", 32'(gnt), 32'(m_gnt));
            chk("rom_en", 32'(rom_en), 32'(m_en));
            if (m_en) begin
                chk("rom_row", 32'(rom_row), 32'(m_row));
                chk("rom_col", 32'(rom_col), 32'(m_col));
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            if (m_rsp_valid != 0) chk("rsp_wall", 32'(rsp_wall), 32'(m_rsp_wall));
            chk("disp_rgb", 32'(disp_rgb), 32'(m_disp_rgb));
            chk("disp_wall", 32'(disp_wall), 32'(m_disp_rgb != 12'h000));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_q(input int i, input int r, input int c);
        req_row[9*i +: 9] = 9'(r);
        req_col[9*i +: 9] = 9'(c);
    endtask

    initial begin
        logic [N-1:0] exp_order [6];
        step(); step();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_rom", 32'({rom_en, rom_row, rom_col}), 32'd0);
        chk("reset_rsp", 32'({rsp_valid, rsp_wall}), 32'd0);
        chk("reset_disp", 32'({disp_rgb, disp_wall}), 32'd0);
        reset = 1'b0;

        // Idle display, requester 0 queries the wall at (0,0).
        req = 5'b00001; set_q(0, 0, 0);
        step();
        chk("q0_gnt", 32'(gnt), 32'h01);
        chk("q0_rom_en", 32'(rom_en), 32'd1);
        req = '0;
        step();
        chk("q0_rsp_valid", 32'(rsp_valid), 32'h01);
        chk("q0_rsp_wall", 32'(rsp_wall), 32'd1);

        // Display and request rise together; display holds the port for 4 cycles.
        disp_active = 1'b1; disp_row = 9'd10; disp_col = 9'd20;
        req = 5'b00100; set_q(2, 3, 5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("disp_pri_gnt", 32'(gnt), 32'd0);
        end
        disp_active = 1'b0;
        step();
        chk("pend_gnt", 32'(gnt), 32'h04);
        req = '0;
        step();
        chk("pend_rsp_valid", 32'(rsp_valid), 32'h04);
        chk("pend_rsp_wall", 32'(rsp_wall), 32'd1);
        chk("query_disp_rgb", 32'(disp_rgb), 32'd0);

        // Display read of (0,0).
        disp_active = 1'b1; disp_row = 9'd0; disp_col = 9'd0;
        step();
        disp_active = 1'b0;
        step();
        chk("disp_rgb", 32'(disp_rgb), 32'h00F);
        chk("disp_wall", 32'(disp_wall), 32'd1);

        // Out-of-range row, then the last in-range pixel, then out-of-range column.
        req = 5'b01000; set_q(3, 310, 5);
        step();
        chk("oor_gnt", 32'(gnt), 32'h08);
        chk("oor_rom_en", 32'(rom_en), 32'd0);
        req = 5'b10000; set_q(4, 309, 279);
        step();
        chk("oor_rsp_wall", 32'(rsp_wall), 32'd1);
        chk("edge_rom_en", 32'(rom_en), 32'd1);
        req = 5'b10000; set_q(4, 0, 280);
        step();
        chk("col_oor_rom_en", 32'(rom_en), 32'd0);
        req = '0;
        step();
        chk("col_oor_rsp_wall", 32'(rsp_wall), 32'd1);

        // All requesters held from a fresh reset.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < N; i++) set_q(i, 2 * i, i + 1);
        req = 5'b11111;
`ifdef MAZE_ARB_RR_EN
        exp_order = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
`else
        exp_order = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif
        for (int i = 0; i < 6; i++) begin
            step();
            chk("all_req_order", 32'(gnt), 32'(exp_order[i]));
        end
        req = '0;
        step(); step();

        // Reset the cycle after a grant: the query must vanish.
        req = 5'b00010; set_q(1, 4, 6);
        step();
        chk("rst_q_gnt", 32'(gnt), 32'h02);
        reset = 1'b1; req = '0;
        step();
        chk("rst_q_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_q_outs", 32'({gnt, rsp_wall, rom_en, rom_row, rom_col}), 32'd0);
        chk("rst_q_disp", 32'({disp_rgb, disp_wall}), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_q_rsp_after", 32'(rsp_valid), 32'd0);

        // Mixed traffic: display bursts, varying request sets and coordinates.
        for (int i = 0; i < 48; i++) begin
            disp_active = (i % 7) < 2;
            disp_row = 9'((i * 5) % 310);
            disp_col = 9'((i * 9) % 280);
            req = 5'((i * 11 + 3) % 32);
            for (int j = 0; j < N; j++) set_q(j, (i * 7 + j * 31) % 330, (i * 13 + j * 17) % 300);
            step();
        end
        req = '0; disp_active = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
